// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode-stage register file bus: read ports, writeback, issue and hazard signals
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                RegWEn;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     mux_out;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic                issue_waw;

    // Core side: decode/writeback/hazard logic drives addresses and commands.
    modport master (
        output rs_addr, RegWEn, rd, mux_out, issue_en, issue_rd, flush,
        input  rs_data, rs_busy, issue_waw
    );

    // Register file side.
    modport slave (
        input  rs_addr, RegWEn, rd, mux_out, issue_en, issue_rd, flush,
        output rs_data, rs_busy, issue_waw
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with N read ports, write bypass and busy-bit scoreboard
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    reg_file_sb_if.slave  bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic             wr_en;
    logic             iss_en;
    logic [AW-1:0]    rd_addr [NRD];

    logic [NRD*XLEN-1:0] rs_data_w;
    logic [NRD-1:0]      rs_busy_w;
    logic                issue_waw_w;

    // Writes and issues aimed at a hardwired r0 are dropped before they touch any state.
    always_comb begin
        wr_en  = bus.RegWEn   && !(ZR && (bus.rd == '0));
        iss_en = bus.issue_en && !(ZR && (bus.issue_rd == '0));
    end

    // Unpack the flat read-address bus into one address per port.
    for (genvar p = 0; p < NRD; p++) begin : g_addr
        assign rd_addr[p] = bus.rs_addr[p*AW +: AW];
    end

    // Next register contents: the single writeback port updates one entry.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.rd] = bus.mux_out;
        end
    end

    // Next busy bits: flush beats issue, issue beats a same-cycle writeback of the same register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_en && (bus.issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (bus.RegWEn && (bus.rd == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers; reset clears data and scoreboard at once, independent of the clock.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: r0 hardwired, then bypass of the in-flight writeback, then stored state.
    always_comb begin
        rs_data_w = '0;
        rs_busy_w = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ZR && (rd_addr[p] == '0)) begin
                rs_data_w[p*XLEN +: XLEN] = '0;
                rs_busy_w[p]              = 1'b0;
            end else if (BP && wr_en && (bus.rd == rd_addr[p])) begin
                rs_data_w[p*XLEN +: XLEN] = bus.mux_out;
                rs_busy_w[p]              = 1'b0;
            end else begin
                rs_data_w[p*XLEN +: XLEN] = regs_q[rd_addr[p]];
                rs_busy_w[p]              = busy_q[rd_addr[p]];
            end
        end
    end

    // WAW: destination still owed a result, unless this very cycle's writeback retires it.
    always_comb begin
        issue_waw_w = bus.issue_en && busy_q[bus.issue_rd]
                      && !(bus.RegWEn && (bus.rd == bus.issue_rd));
        if (ZR && (bus.issue_rd == '0)) begin
            issue_waw_w = 1'b0;
        end
    end

    assign bus.rs_data   = rs_data_w;
    assign bus.rs_busy   = rs_busy_w;
    assign bus.issue_waw = issue_waw_w;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb in three configurations
module tb_reg_file_sb;
    logic cpu_clk;
    logic cpu_rst_n;
    int   checks;
    int   failures;

    // m: NRD=4 ZERO_REG=1 BYPASS=1; nb: BYPASS=0; nz: ZERO_REG=0
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(4)) m_if ();
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) nb_if ();
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) nz_if ();

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(4), .ZERO_REG(1), .BYPASS(1)) u_m (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bus(m_if));
    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bus(nb_if));
    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0), .BYPASS(1)) u_nz (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bus(nz_if));

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                         input logic ien, input logic [4:0] ird, input logic fl);
        m_if.RegWEn  = wen; m_if.rd  = rd; m_if.mux_out  = data;
        m_if.issue_en = ien; m_if.issue_rd = ird; m_if.flush = fl;
        nb_if.RegWEn = wen; nb_if.rd = rd; nb_if.mux_out = data;
        nb_if.issue_en = ien; nb_if.issue_rd = ird; nb_if.flush = fl;
        nz_if.RegWEn = wen; nz_if.rd = rd; nz_if.mux_out = data;
        nz_if.issue_en = ien; nz_if.issue_rd = ird; nz_if.flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cpu_rst_n = 1'b0;
        idle();
        m_if.rs_addr  = '0;
        nb_if.rs_addr = '0;
        nz_if.rs_addr = '0;
        tick();
        tick();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        tick();

        // Reset state
        m_if.rs_addr = {5'd31, 5'd12, 5'd5, 5'd0};
        #1;
        check("rst_data_p1", m_if.rs_data[63:32], 32'h0);
        check("rst_busy", {28'h0, m_if.rs_busy}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
        #1;
        check("rst_waw", {31'h0, m_if.issue_waw}, 32'h0);

        // 1: async reset mid-cycle
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0);
        tick();
        idle();
        m_if.rs_addr = {5'd0, 5'd0, 5'd6, 5'd5};
        #1;
        check("t1_pre_data", m_if.rs_data[31:0], 32'hDEADBEEF);
        check("t1_pre_busy6", {31'h0, m_if.rs_busy[1]}, 32'h1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check("t1_rst_data", m_if.rs_data[31:0], 32'h0);
        check("t1_rst_busy", {28'h0, m_if.rs_busy}, 32'h0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        tick();

        // 2: bypass vs no bypass, with r7 already busy
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        tick();
        drive(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b0);
        m_if.rs_addr  = {5'd0, 5'd0, 5'd0, 5'd7};
        nb_if.rs_addr = {5'd0, 5'd7};
        #1;
        check("t2_byp_data", m_if.rs_data[31:0], 32'h1234);
        check("t2_byp_busy", {31'h0, m_if.rs_busy[0]}, 32'h0);
        check("t2_nobyp_data", nb_if.rs_data[31:0], 32'h0);
        check("t2_nobyp_busy", {31'h0, nb_if.rs_busy[0]}, 32'h1);
        tick();
        idle();
        #1;
        check("t2_nobyp_next", nb_if.rs_data[31:0], 32'h1234);
        check("t2_nobyp_nbusy", {31'h0, nb_if.rs_busy[0]}, 32'h0);

        // 3: register zero handling
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
        m_if.rs_addr  = '0;
        nz_if.rs_addr = '0;
        #1;
        check("t3_z_wr_data", m_if.rs_data[31:0], 32'h0);
        check("t3_nz_byp", nz_if.rs_data[31:0], 32'hFFFFFFFF);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        tick();
        #1;
        check("t3_z_data", m_if.rs_data[31:0], 32'h0);
        check("t3_z_busy", {31'h0, m_if.rs_busy[0]}, 32'h0);
        check("t3_z_waw", {31'h0, m_if.issue_waw}, 32'h0);
        check("t3_nz_data", nz_if.rs_data[31:0], 32'hFFFFFFFF);
        check("t3_nz_busy", {31'h0, nz_if.rs_busy[0]}, 32'h1);
        check("t3_nz_waw", {31'h0, nz_if.issue_waw}, 32'h1);
        idle();

        // 4: scoreboard set and clear
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        tick();
        idle();
        m_if.rs_addr = {5'd0, 5'd3, 5'd0, 5'd0};
        #1;
        check("t4_busy_set", {31'h0, m_if.rs_busy[2]}, 32'h1);
        check("t4_data_old", m_if.rs_data[95:64], 32'h0);
        drive(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0);
        #1;
        check("t4_wb_byp", m_if.rs_data[95:64], 32'hA5);
        tick();
        idle();
        #1;
        check("t4_busy_clr", {31'h0, m_if.rs_busy[2]}, 32'h0);
        check("t4_data", m_if.rs_data[95:64], 32'hA5);

        // 5: issue and writeback of the same register in one cycle
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0);
        tick();
        idle();
        m_if.rs_addr = {5'd4, 5'd0, 5'd0, 5'd0};
        #1;
        check("t5_busy", {31'h0, m_if.rs_busy[3]}, 32'h1);
        check("t5_data", m_if.rs_data[127:96], 32'h44);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        #1;
        check("t5_waw", {31'h0, m_if.issue_waw}, 32'h1);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0);
        #1;
        check("t5_waw_wb", {31'h0, m_if.issue_waw}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        tick();
        idle();
        #1;
        check("t5_busy_kept", {31'h0, m_if.rs_busy[3]}, 32'h1);

        // 6: flush overrides same-cycle issue, data kept
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        tick();
        idle();
        m_if.rs_addr = {5'd9, 5'd4, 5'd2, 5'd1};
        #1;
        check("t6_pre_busy", {28'h0, m_if.rs_busy}, 32'hF);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1);
        tick();
        idle();
        #1;
        check("t6_busy_a", {28'h0, m_if.rs_busy}, 32'h0);
        m_if.rs_addr = {5'd10, 5'd7, 5'd4, 5'd3};
        #1;
        check("t6_busy_b", {28'h0, m_if.rs_busy}, 32'h0);
        check("t6_r3", m_if.rs_data[31:0], 32'hA5);
        check("t6_r4", m_if.rs_data[63:32], 32'h44);
        check("t6_r7", m_if.rs_data[95:64], 32'h1234);
        check("t6_r10", m_if.rs_data[127:96], 32'h0);
        nz_if.rs_addr = {5'd0, 5'd0};
        #1;
        check("t6_nz_busy0", {31'h0, nz_if.rs_busy[0]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
